// File: rtl/shift_engine.sv
// Handshaked full-duplex shift engine: loads an N-bit word, shifts STEP bits per enabled cycle.
// Optional SHIFT_ENGINE_ROTATE_EN adds a Rotate input that recirculates the exiting bits.
module shift_engine #(
  parameter int N    = 16,
  parameter int STEP = 1
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            LoadValid,
  output logic            LoadReady,
  input  logic [N-1:0]    In,
  input  logic            Dir,
`ifdef SHIFT_ENGINE_ROTATE_EN
  input  logic            Rotate,
`endif
  input  logic            ShiftEnable,
  input  logic [STEP-1:0] ShiftIn,
  output logic [STEP-1:0] ShiftOut,
  input  logic            Abort,
  output logic            Busy,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [N-1:0]    Out
);
  localparam int NSH = N / STEP;
  localparam int CW  = $clog2(NSH + 1);

  if (N < 2 || STEP < 1 || STEP > N || (N % STEP) != 0) begin : g_param_check
    $error("shift_engine: N must be >= 2 and a multiple of STEP (1 <= STEP <= N)");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, state_nx;
  logic [N-1:0]    sr, sr_nx, sr_r, sr_l;
  logic            d, d_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [STEP-1:0] fill;

  assign ShiftOut = d ? sr[N-1 -: STEP] : sr[STEP-1:0];

`ifdef SHIFT_ENGINE_ROTATE_EN
  logic rot, rot_nx;
  assign fill = rot ? ShiftOut : ShiftIn;
`else
  assign fill = ShiftIn;
`endif

  // A full-width step replaces the whole register, so no residue slice exists.
  if (STEP == N) begin : g_full
    assign sr_r = fill;
    assign sr_l = fill;
  end else begin : g_part
    assign sr_r = {fill, sr[N-1:STEP]};
    assign sr_l = {sr[N-STEP-1:0], fill};
  end

  always_comb begin
    state_nx = state;
    sr_nx    = sr;
    d_nx     = d;
    cnt_nx   = cnt;
`ifdef SHIFT_ENGINE_ROTATE_EN
    rot_nx   = rot;
`endif
    case (state)
      IDLE: if (LoadValid) begin
        sr_nx    = In;
        d_nx     = Dir;
        cnt_nx   = CW'(NSH);
        state_nx = SHIFT;
`ifdef SHIFT_ENGINE_ROTATE_EN
        rot_nx   = Rotate;
`endif
      end
      SHIFT: if (ShiftEnable) begin
        sr_nx  = d ? sr_l : sr_r;
        cnt_nx = cnt - CW'(1);
        if (cnt == CW'(1)) state_nx = DONE;
      end
      DONE: if (OutReady) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // Abort wins over load, shift and output handshake alike.
    if (Abort) begin
      state_nx = IDLE;
      sr_nx    = '0;
      cnt_nx   = '0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      sr    <= '0;
      d     <= 1'b0;
      cnt   <= '0;
`ifdef SHIFT_ENGINE_ROTATE_EN
      rot   <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      sr    <= sr_nx;
      d     <= d_nx;
      cnt   <= cnt_nx;
`ifdef SHIFT_ENGINE_ROTATE_EN
      rot   <= rot_nx;
`endif
    end
  end

  assign LoadReady = (state == IDLE);
  assign Busy      = (state == SHIFT);
  assign OutValid  = (state == DONE);
  assign Out       = sr;

endmodule

// File: tb/tb_shift_engine.sv
// Self-checking bench for shift_engine: bit-queue reference model for STEP=1, nibble arithmetic for STEP=4.
module tb_shift_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        ld_v, ld_rdy, dir, sh_en, sh_in, sh_out, abort, busy, o_v, o_rdy, rot;
  logic [15:0] in_w, o_w;
  logic        ld_v4, ld_rdy4, dir4, en4, ab4, busy4, o_v4, o_rdy4;
  logic [3:0]  si4, so4;
  logic [15:0] in4, o_w4;

  int pass = 0, total = 0;

  bit          obs_q[$], exp_q[$];
  int          busy_cyc, en_cnt;
  logic [15:0] exp_word;

  shift_engine #(.N(16), .STEP(1)) u1 (
    .Clk(clk), .Reset(rst_n), .LoadValid(ld_v), .LoadReady(ld_rdy), .In(in_w), .Dir(dir),
`ifdef SHIFT_ENGINE_ROTATE_EN
    .Rotate(rot),
`endif
    .ShiftEnable(sh_en), .ShiftIn(sh_in), .ShiftOut(sh_out), .Abort(abort), .Busy(busy),
    .OutValid(o_v), .OutReady(o_rdy), .Out(o_w));

  shift_engine #(.N(16), .STEP(4)) u4 (
    .Clk(clk), .Reset(rst_n), .LoadValid(ld_v4), .LoadReady(ld_rdy4), .In(in4), .Dir(dir4),
`ifdef SHIFT_ENGINE_ROTATE_EN
    .Rotate(1'b0),
`endif
    .ShiftEnable(en4), .ShiftIn(si4), .ShiftOut(so4), .Abort(ab4), .Busy(busy4),
    .OutValid(o_v4), .OutReady(o_rdy4), .Out(o_w4));

  // Loads w, then shifts until Busy drops. mode 0: enable every cycle, 1: odd cycles only, 2: random.
  // Fill bits come from src (LSB first when d=0, MSB first when d=1) or random in mode 2.
  task automatic drive_word(input logic [15:0] w, input bit d, input int mode, input logic [15:0] src);
    bit m[$];
    bit en, fb, ex;
    int cyc = 0;
    obs_q.delete(); exp_q.delete();
    busy_cyc = 0; en_cnt = 0;
    for (int i = 0; i < 16; i++) m.push_back(w[i]);
    ld_v = 1; in_w = w; dir = d; sh_en = 1; sh_in = 1'($urandom);
    @(posedge clk); #1;
    ld_v = 0; in_w = 16'($urandom); dir = 1'($urandom);
    while (busy && cyc < 200) begin
      busy_cyc++;
      en = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 1) : 1'($urandom);
      fb = (mode == 2) ? 1'($urandom) : (d ? src[15 - en_cnt] : src[en_cnt]);
      sh_en = en; sh_in = fb;
      ex = d ? m[15] : m[0];
      obs_q.push_back(sh_out); exp_q.push_back(ex);
      @(posedge clk); #1;
      if (en) begin
        if (rot) fb = ex;
        if (!d) begin void'(m.pop_front()); m.push_back(fb); end
        else    begin void'(m.pop_back());  m.push_front(fb); end
        en_cnt++;
      end
      cyc++;
    end
    sh_en = 0;
    for (int i = 0; i < 16; i++) exp_word[i] = m[i];
  endtask

  task automatic handshake();
    o_rdy = 1;
    @(posedge clk); #1;
    o_rdy = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    #7;
    total++; if (ld_rdy !== 1'b1 || busy !== 1'b0 || o_v !== 1'b0) begin
      $display("FAIL reset_ctrl got rdy=%b busy=%b ov=%b want 1 0 0", ld_rdy, busy, o_v);
    end else pass++;
    total++; if (o_w !== 16'h0 || sh_out !== 1'b0) begin
      $display("FAIL reset_data got out=%h sout=%b want 0000 0", o_w, sh_out);
    end else pass++;
    total++; if (ld_rdy4 !== 1'b1 || o_w4 !== 16'h0 || so4 !== 4'h0) begin
      $display("FAIL reset_step4 got rdy=%b out=%h sout=%h want 1 0000 0", ld_rdy4, o_w4, so4);
    end else pass++;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_right_step1();
    drive_word(16'hA5C3, 1'b0, 0, 16'hFFFF);
    total++; if (busy_cyc !== 16 || en_cnt !== 16) begin
      $display("FAIL right_busy got busy=%0d shifts=%0d want 16 16", busy_cyc, en_cnt);
    end else pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin
        $display("FAIL right_sout[%0d] got %b want %b", i, obs_q[i], exp_q[i]);
      end else pass++;
    end
    total++; if (o_v !== 1'b1 || o_w !== 16'hFFFF || o_w !== exp_word) begin
      $display("FAIL right_out got ov=%b out=%h want 1 ffff", o_v, o_w);
    end else pass++;
    handshake();
    total++; if (ld_rdy !== 1'b1 || o_v !== 1'b0) begin
      $display("FAIL right_hs got rdy=%b ov=%b want 1 0", ld_rdy, o_v);
    end else pass++;
  endtask

  task automatic test_left_gaps();
    drive_word(16'h0000, 1'b1, 1, 16'h1234);
    total++; if (busy_cyc !== 32 || en_cnt !== 16) begin
      $display("FAIL left_busy got busy=%0d shifts=%0d want 32 16", busy_cyc, en_cnt);
    end else pass++;
    total++; if (o_v !== 1'b1 || o_w !== 16'h1234) begin
      $display("FAIL left_out got ov=%b out=%h want 1 1234", o_v, o_w);
    end else pass++;
    handshake();
  endtask

  task automatic test_random();
    logic [15:0] w;
    bit d;
    int bad;
    for (int n = 0; n < 6; n++) begin
      w = 16'($urandom); d = 1'($urandom);
      drive_word(w, d, 2, 16'h0);
      total++; if (en_cnt !== 16 || o_v !== 1'b1 || o_w !== exp_word) begin
        $display("FAIL rand%0d_out got shifts=%0d ov=%b out=%h want 16 1 %h", n, en_cnt, o_v, o_w, exp_word);
      end else pass++;
      bad = 0;
      for (int i = 0; i < exp_q.size(); i++) if (obs_q[i] !== exp_q[i]) bad++;
      total++; if (bad !== 0) begin
        $display("FAIL rand%0d_sout got %0d bad bits want 0 (w=%h d=%b)", n, bad, w, d);
      end else pass++;
      handshake();
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] held;
    drive_word(16'($urandom), 1'($urandom), 0, 16'($urandom));
    held = exp_word;
    ld_v = 1; in_w = 16'($urandom); sh_en = 1; sh_in = 1'($urandom);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++; if (o_v !== 1'b1 || o_w !== held || ld_rdy !== 1'b0 || busy !== 1'b0) begin
        $display("FAIL bp_hold[%0d] got ov=%b out=%h rdy=%b want 1 %h 0", i, o_v, o_w, ld_rdy, held);
      end else pass++;
    end
    handshake();
    total++; if (ld_rdy !== 1'b1 || o_v !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL bp_release got rdy=%b ov=%b busy=%b want 1 0 0", ld_rdy, o_v, busy);
    end else pass++;
    ld_v = 0; sh_en = 0;
  endtask

  task automatic test_abort();
    logic [15:0] w, want;
    bit d;
    w = 16'($urandom); d = 1'($urandom);
    ld_v = 1; in_w = w; dir = d; sh_in = 0;
    @(posedge clk); #1;
    ld_v = 0; sh_en = 1;
    repeat (7) begin @(posedge clk); #1; end
    want = d ? (w << 7) : (w >> 7);
    total++; if (o_w !== want || busy !== 1'b1) begin
      $display("FAIL abort_pre got out=%h busy=%b want %h 1", o_w, busy, want);
    end else pass++;
    abort = 1; ld_v = 1; in_w = 16'($urandom);
    @(posedge clk); #1;
    abort = 0; ld_v = 0; sh_en = 0;
    total++; if (ld_rdy !== 1'b1 || busy !== 1'b0 || o_v !== 1'b0 || o_w !== 16'h0 || sh_out !== 1'b0) begin
      $display("FAIL abort_post got rdy=%b busy=%b ov=%b out=%h want 1 0 0 0000", ld_rdy, busy, o_v, o_w);
    end else pass++;
  endtask

  task automatic test_reset_midshift();
    ld_v = 1; in_w = 16'hFFFF; dir = 1; sh_in = 1;
    @(posedge clk); #1;
    ld_v = 0; sh_en = 1;
    repeat (7) begin @(posedge clk); #1; end
    #2 rst_n = 0;
    #1;
    total++; if (ld_rdy !== 1'b1 || busy !== 1'b0 || o_v !== 1'b0 || o_w !== 16'h0 || sh_out !== 1'b0) begin
      $display("FAIL rst_mid got rdy=%b busy=%b ov=%b out=%h sout=%b want 1 0 0 0000 0", ld_rdy, busy, o_v, o_w, sh_out);
    end else pass++;
    sh_en = 0;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    total++; if (ld_rdy !== 1'b1 || o_v !== 1'b0 || o_w !== 16'h0) begin
      $display("FAIL rst_after got rdy=%b ov=%b out=%h want 1 0 0000", ld_rdy, o_v, o_w);
    end else pass++;
  endtask

  task automatic test_step4();
    logic [15:0] w, want;
    logic [3:0]  f;
    logic [3:0]  nib;
    // right shift of 0xBEEF with zero fill
    ld_v4 = 1; in4 = 16'hBEEF; dir4 = 0; si4 = 4'h0; en4 = 1;
    @(posedge clk); #1;
    ld_v4 = 0;
    for (int k = 0; k < 4; k++) begin
      nib = 4'(16'hBEEF >> (4 * k));
      total++; if (so4 !== nib || busy4 !== 1'b1) begin
        $display("FAIL s4_right[%0d] got %h busy=%b want %h 1", k, so4, busy4, nib);
      end else pass++;
      @(posedge clk); #1;
    end
    en4 = 0;
    total++; if (o_v4 !== 1'b1 || o_w4 !== 16'h0 || busy4 !== 1'b0) begin
      $display("FAIL s4_right_out got ov=%b out=%h want 1 0000", o_v4, o_w4);
    end else pass++;
    o_rdy4 = 1; @(posedge clk); #1; o_rdy4 = 0;
    // random word shifted left with random fill nibbles
    w = 16'($urandom); want = 16'h0;
    ld_v4 = 1; in4 = w; dir4 = 1; en4 = 1;
    @(posedge clk); #1;
    ld_v4 = 0; dir4 = 0;
    for (int k = 0; k < 4; k++) begin
      f = 4'($urandom); si4 = f;
      want = want | (16'(f) << (12 - 4 * k));
      nib = 4'(w >> (12 - 4 * k));
      total++; if (so4 !== nib) begin
        $display("FAIL s4_left[%0d] got %h want %h", k, so4, nib);
      end else pass++;
      @(posedge clk); #1;
    end
    en4 = 0;
    total++; if (o_v4 !== 1'b1 || o_w4 !== want) begin
      $display("FAIL s4_left_out got ov=%b out=%h want 1 %h", o_v4, o_w4, want);
    end else pass++;
    o_rdy4 = 1; @(posedge clk); #1; o_rdy4 = 0;
    total++; if (ld_rdy4 !== 1'b1 || o_v4 !== 1'b0) begin
      $display("FAIL s4_hs got rdy=%b ov=%b want 1 0", ld_rdy4, o_v4);
    end else pass++;
  endtask

`ifdef SHIFT_ENGINE_ROTATE_EN
  task automatic test_rotate();
    int bad = 0;
    rot = 1;
    drive_word(16'hBEEF, 1'b1, 0, 16'($urandom));
    for (int i = 0; i < exp_q.size(); i++) if (obs_q[i] !== exp_q[i]) bad++;
    total++; if (bad !== 0 || en_cnt !== 16) begin
      $display("FAIL rot_sout got %0d bad bits, %0d shifts want 0 16", bad, en_cnt);
    end else pass++;
    total++; if (o_v !== 1'b1 || o_w !== 16'hBEEF) begin
      $display("FAIL rot_out got ov=%b out=%h want 1 beef", o_v, o_w);
    end else pass++;
    handshake();
    rot = 0;
  endtask
`endif

  initial begin
    rst_n = 0; ld_v = 0; in_w = 0; dir = 0; sh_en = 0; sh_in = 0; abort = 0; o_rdy = 0; rot = 0;
    ld_v4 = 0; in4 = 0; dir4 = 0; en4 = 0; si4 = 0; ab4 = 0; o_rdy4 = 0;
    test_reset();
    test_right_step1();
    test_left_gaps();
    test_random();
    test_backpressure();
    test_abort();
    test_reset_midshift();
    test_step4();
`ifdef SHIFT_ENGINE_ROTATE_EN
    test_rotate();
`endif
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/shift_engine.md
Name: shift_engine

Overview:
- Parametrised, handshaked shift engine; successor to the single-direction right-shift register.
- Accepts an N-bit word and shifts it out STEP bits per enabled cycle, LSB- or MSB-first. Simultaneously shifts the same number of bits in (full-duplex, SPI-style).
- Presents the assembled word on a valid/ready output.
- Used by serial peripherals (SPI/UART-style front ends) attached to the datapath.

Parameters:
- N, 16, word width in bits; N >= 2.
- STEP, 1, bits moved per shift; 1 <= STEP <= N, N % STEP == 0; otherwise elaboration error.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- LoadValid  in  1  In/Dir valid.
- LoadReady  out  1  engine can accept a word.
- In  in  N  word to shift out.
- Dir  in  1  sampled at load; 0 = right (LSB first), 1 = left (MSB first).
- ShiftEnable  in  1  strobe; one shift per cycle it is high in SHIFT.
- ShiftIn  in  STEP  serial bits entering the vacated end.
- ShiftOut  out  STEP  bits at the exiting end of the shift register.
- Abort  in  1  synchronous cancel.
- Busy  out  1  high in SHIFT.
- OutValid  out  1  Out holds a completed word.
- OutReady  in  1  consumer accepts Out.
- Out  out  N  shift register contents.

Behaviour:
- State: FSM {IDLE, SHIFT, DONE}, shift register Sr[N-1:0], latched direction D, counter Cnt of width clog2(N/STEP+1).
- Reset asserted (async): state = IDLE, Sr = 0, D = 0, Cnt = 0.
  - Outputs under reset: LoadReady = 1, Busy = 0, OutValid = 0, Out = 0, ShiftOut = 0.
  - Applies at any time, including mid-shift; no partial word is ever presented afterwards.
- Out = Sr at all times.
- ShiftOut = Sr[STEP-1:0] when D = 0; Sr[N-1:N-STEP] when D = 1. Combinational from registers.
- IDLE:
  - LoadReady = 1.
  - On LoadValid: Sr <= In, D <= Dir, Cnt <= N/STEP, next state SHIFT.
  - Load-to-first-shift latency is 1 cycle.
- SHIFT:
  - LoadReady = 0, Busy = 1.
  - On ShiftEnable with D = 0: Sr <= {ShiftIn, Sr[N-1:STEP]}.
  - On ShiftEnable with D = 1: Sr <= {Sr[N-STEP-1:0], ShiftIn}; when STEP = N, Sr <= ShiftIn.
  - Each enabled shift decrements Cnt. The shift taken with Cnt = 1 moves the state to DONE.
  - Cycles with ShiftEnable low hold all state.
- DONE:
  - OutValid = 1; Out stable until handshake.
  - OutValid & OutReady: next state IDLE.
  - LoadReady = 0 in DONE. A load is accepted no earlier than the cycle after the output handshake.
  - ShiftEnable is ignored.
- Abort (synchronous, highest priority after reset):
  - From any state: next state IDLE, Sr <= 0, Cnt <= 0.
  - Abort overrides a simultaneous LoadValid, ShiftEnable or output handshake.
- Simultaneous LoadValid and ShiftEnable in IDLE: load only; no shift that cycle.
- OutReady outside DONE is ignored.
- Dir changes after load have no effect until the next load.

Optional Feature:
- Macro: SHIFT_ENGINE_ROTATE_EN.
- When defined:
  - Adds input port Rotate (1 bit), sampled and latched with Dir at load.
  - With latched Rotate = 1, ShiftIn is ignored and the exiting bits (ShiftOut) re-enter the vacated end.
  - After N/STEP shifts, Out equals the loaded word.
- When undefined: no Rotate port; fill always comes from ShiftIn.

Test Plan:
- Right shift, STEP = 1. Load 0xA5C3, Dir = 0, ShiftIn = 1, ShiftEnable = 1 continuously.
  -> ShiftOut sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
  -> Busy for exactly 16 cycles, then OutValid = 1 with Out = 0xFFFF.
- Left shift with gaps. Load 0x0000, Dir = 1. Feed ShiftIn with bits of 0x1234 MSB first, ShiftEnable high every other cycle.
  -> DONE after the 16th enabled cycle (32 cycles), Out = 0x1234.
- STEP = 4. Load 0xBEEF, Dir = 0, ShiftIn = 0x0.
  -> ShiftOut F,E,E,B over 4 enables; Out = 0x0000, OutValid = 1.
- Backpressure. Complete a word, hold OutReady = 0 for 5 cycles, then 1.
  -> OutValid and Out stable for 6 cycles; LoadReady = 1 the cycle after the handshake.
- Abort and reset. Assert Abort after 7 shifts.
  -> IDLE, LoadReady = 1, Out = 0 the next cycle.
  -> Repeat, but drop Reset mid-cycle: outputs go to reset values immediately, without a clock edge.
- Rotate, macro defined. Load 0xBEEF, Rotate = 1, Dir = 1, STEP = 1.
  -> ShiftOut 1,0,1,1,1,1,1,0,...; final Out = 0xBEEF.
